interval_timer: RTL and testbench
=================================

# interval_timer

Parametrised, programmable interval timer: the general-purpose successor to the fixed 11-bit all-ones up-counter. It counts prescaled ticks from 0 up to a limit latched at start. It runs one-shot or periodic, supports pause via Enable and abort via Stop, and reports a one-cycle Done pulse plus a sticky Expired level. It sits between the game control FSM and the display/score logic, timing the random pre-stimulus delay and the reaction window.

## Interface
- WIDTH, default 11: counter and Limit width in bits; legal range 2..32.
- PRESCALE, default 1: Clock cycles per count tick; legal range 1..65535; prescaler width = clog2(PRESCALE), minimum 1.
- Clock  in  1  rising-edge clock.
- Reset  in  1  synchronous, active-low; clock Clock.
- Enable  in  1  count gate; low freezes both the prescaler and Count while the timer is RUN.
- Start  in  1  single-cycle request: latch Limit and Mode, clear Count and the prescaler, enter RUN.
- Stop  in  1  single-cycle abort: return to IDLE and hold Count.
- Mode  in  1  0 = one-shot, 1 = periodic; sampled only on Start.
- Limit  in  WIDTH  terminal count; sampled only on Start.
- Count  out  WIDTH  current count, registered.
- Running  out  1  high while the timer is in RUN.
- Done  out  1  registered single-cycle pulse per terminal tick.
- Expired  out  1  level; high in EXPIRED.

## Operation
- States: IDLE, RUN, EXPIRED.
- On Reset low: state IDLE; Count, prescaler, limit_q, mode_q, Done and Expired all 0; Running 0.
- Priority per edge is Reset > Stop > Start > tick.
- Stop: from any state go to IDLE. Count is held, Done is 0 and Expired is 0.
- Start, when Stop is low: from any state, including RUN (restart), do the following:
  - limit_q = Limit, mode_q = Mode.
  - Count = 0, prescaler = 0.
  - Go to RUN.
  - A tick does not occur on the Start edge.
- tick: state RUN, Enable = 1 and prescaler == PRESCALE-1. The prescaler wraps to 0 on a tick and otherwise increments while RUN and Enable are both high.
- On tick with Count != limit_q: Count = Count+1 (modulo 2^WIDTH is never reached, because Count ≤ limit_q).
- On tick with Count == limit_q: Done = 1 on the next cycle, then:
  - One-shot: go to EXPIRED; Count is held at limit_q.
  - Periodic: Count = 0; stay in RUN.
- Limit = 0 is legal: Done fires on the first tick, every tick when periodic.
- Limit = 2^WIDTH-1 with one-shot reproduces the legacy all-ones behaviour.
- EXPIRED holds until Start, Stop or Reset.
- In EXPIRED and IDLE, Enable and ticks are ignored.
- Changes to Limit and Mode during RUN have no effect until the next Start.

## Timing
- All outputs are registered; there is no combinational input-to-output path.
- Start at edge e0 gives Count = 0 and Running = 1 after e0.
- With Enable held high, Done is high for exactly one cycle, after edge e0 + (L+1)·PRESCALE.
- Enable low for N cycles during RUN delays Done by exactly N cycles.
- Periodic Done spacing is (L+1)·PRESCALE cycles.
- Expired rises on the same edge as Done in one-shot mode.
- Start in the same cycle as a terminal tick: restart wins and Done is not asserted.
- Stop in the same cycle as Start: the result is IDLE.
- Reset mid-count: all outputs return to their reset values after that edge.

## Structure
- Shared package/header timer_pkg holds:
  - the state encodings ST_IDLE = 2'd0, ST_RUN = 2'd1, ST_EXPIRED = 2'd2;
  - the mode constants MODE_ONESHOT = 1'b0, MODE_PERIODIC = 1'b1.
- Sub-module tick_prescaler (parameter PRESCALE; ports Clock, Reset, Clear, Enable, Tick):
  - When PRESCALE = 1 it degenerates to Tick = Enable.
  - It is reused by other timing blocks.
- Top level: state register, limit/mode latches, counter and compare, Done/Expired registers.

## Test plan
- Reset: hold Reset = 0 with Start = 1 → Count = 0, Running = 0, Done = 0, Expired = 0.
- One-shot: WIDTH = 11, PRESCALE = 1, Limit = 5, Start, Enable = 1 → Done one cycle, 6 cycles after Start; Expired = 1; Count held at 5.
- Periodic with prescale: PRESCALE = 4, Limit = 2, Mode = 1 → Done pulses every 12 cycles, at least 3 times; Count sequence 0,1,2,0; Running stays 1.
- Pause and abort:
  - Limit = 10; drop Enable for 7 cycles mid-count → Done delayed exactly 7 cycles.
  - Separate run: Stop at Count = 4 → IDLE, Count = 4, no Done.
- Boundaries:
  - Limit = 0 → Done on the first tick.
  - Limit = 2047 one-shot → Done after 2048 cycles.
  - Start on the terminal-tick cycle → Count = 0, no Done.
  - Start + Stop together → IDLE.
- Reset mid-run: Reset = 0 at Count = 3 → all outputs at reset values on the next cycle; a subsequent Start times correctly.

Source files
------------

// File: rtl/timer_pkg.sv
// rtl/timer_pkg.sv - shared state/mode encodings and sizing helper for timer blocks
package timer_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_RUN     = 2'd1,
        ST_EXPIRED = 2'd2
    } timer_state_t;

    localparam logic MODE_ONESHOT  = 1'b0;
    localparam logic MODE_PERIODIC = 1'b1;

    // Prescaler counter width: clog2(PRESCALE), never below one bit.
    function automatic int unsigned prescale_width(input int unsigned prescale);
        return (prescale <= 2) ? 1 : $clog2(prescale);
    endfunction

endpackage

// File: rtl/tick_prescaler.sv
// rtl/tick_prescaler.sv - divides enabled clock cycles into one Tick every PRESCALE cycles
// Ports: Clock, Reset (sync, active-low), Clear (zero the divider),
//        Enable (advance the divider), Tick (Enable on the last cycle of a period).
module tick_prescaler
    import timer_pkg::*;
#(
    parameter int unsigned PRESCALE = 1
) (
    input  logic Clock,
    input  logic Reset,
    input  logic Clear,
    input  logic Enable,
    output logic Tick
);

    generate
        if (PRESCALE == 1) begin : g_bypass
            // Every enabled cycle is a tick; the divider state is not needed.
            logic unused_inputs;
            assign unused_inputs = ^{Clock, Reset, Clear};
            assign Tick          = Enable;
        end else begin : g_divide
            localparam int unsigned PW = prescale_width(PRESCALE);
            localparam logic [PW-1:0] LAST = PW'(PRESCALE - 1);

            logic [PW-1:0] cnt_q;

            always_ff @(posedge Clock) begin
                if (!Reset) begin
                    cnt_q <= '0;
                end else if (Clear) begin
                    cnt_q <= '0;
                end else if (Enable) begin
                    cnt_q <= (cnt_q == LAST) ? '0 : cnt_q + PW'(1);
                end
            end

            assign Tick = Enable && (cnt_q == LAST);
        end
    endgenerate

endmodule

// File: rtl/interval_timer.sv
// rtl/interval_timer.sv - programmable one-shot/periodic interval timer with prescaler
// Ports: Clock, Reset (sync, active-low), Enable (pause gate), Start (latch Limit/Mode
//        and run), Stop (abort to idle), Mode (0 one-shot, 1 periodic), Limit (terminal
//        count); Count, Running, Done (one-cycle pulse per terminal tick), Expired.
module interval_timer
    import timer_pkg::*;
#(
    parameter int unsigned WIDTH    = 11,
    parameter int unsigned PRESCALE = 1
) (
    input  logic             Clock,
    input  logic             Reset,
    input  logic             Enable,
    input  logic             Start,
    input  logic             Stop,
    input  logic             Mode,
    input  logic [WIDTH-1:0] Limit,
    output logic [WIDTH-1:0] Count,
    output logic             Running,
    output logic             Done,
    output logic             Expired
);

    timer_state_t     state_q;
    timer_state_t     state_d;
    logic [WIDTH-1:0] limit_q;
    logic             mode_q;
    logic             pre_clear;
    logic             pre_enable;
    logic             tick;
    logic             terminal;

    // Start/Stop own the edge they arrive on, so the divider is held off and
    // cleared then; this is what keeps a tick from landing on the Start edge.
    assign pre_clear  = Start || Stop;
    assign pre_enable = (state_q == ST_RUN) && Enable && !pre_clear;
    assign terminal   = tick && (Count == limit_q);

    tick_prescaler #(
        .PRESCALE(PRESCALE)
    ) u_prescaler (
        .Clock (Clock),
        .Reset (Reset),
        .Clear (pre_clear),
        .Enable(pre_enable),
        .Tick  (tick)
    );

    always_ff @(posedge Clock) begin
        if (!Reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (Stop) begin
            state_d = ST_IDLE;
        end else if (Start) begin
            state_d = ST_RUN;
        end else if (terminal && (mode_q == MODE_ONESHOT)) begin
            state_d = ST_EXPIRED;
        end
    end

    // Decoded straight from the state register, so both stay registered outputs.
    always_comb begin
        Running = (state_q == ST_RUN);
        Expired = (state_q == ST_EXPIRED);
    end

    always_ff @(posedge Clock) begin
        if (!Reset) begin
            Count   <= '0;
            limit_q <= '0;
            mode_q  <= MODE_ONESHOT;
            Done    <= 1'b0;
        end else begin
            // terminal already excludes Start/Stop cycles, so a restart suppresses Done.
            Done <= terminal;
            if (Stop) begin
                Count <= Count;
            end else if (Start) begin
                limit_q <= Limit;
                mode_q  <= Mode;
                Count   <= '0;
            end else if (tick) begin
                if (Count == limit_q) begin
                    Count <= (mode_q == MODE_PERIODIC) ? '0 : Count;
                end else begin
                    Count <= Count + WIDTH'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_interval_timer.sv
// tb/tb_interval_timer.sv - self-checking bench for interval_timer at PRESCALE 1 and 4
module tb_interval_timer;

    localparam int W = 11;

    logic         Clock = 1'b0;
    logic         Reset = 1'b0;
    logic         Enable = 1'b0;
    logic         Start = 1'b0;
    logic         Stop = 1'b0;
    logic         Mode = 1'b0;
    logic [W-1:0] Limit = '0;

    logic [W-1:0] count1, count4;
    logic         run1, run4, done1, done4, exp1, exp4;

    int tests = 0;
    int fails = 0;

    always #5 Clock = ~Clock;

    interval_timer #(.WIDTH(W), .PRESCALE(1)) dut1 (
        .Clock(Clock), .Reset(Reset), .Enable(Enable), .Start(Start), .Stop(Stop),
        .Mode(Mode), .Limit(Limit), .Count(count1), .Running(run1), .Done(done1),
        .Expired(exp1)
    );

    interval_timer #(.WIDTH(W), .PRESCALE(4)) dut4 (
        .Clock(Clock), .Reset(Reset), .Enable(Enable), .Start(Start), .Stop(Stop),
        .Mode(Mode), .Limit(Limit), .Count(count4), .Running(run4), .Done(done4),
        .Expired(exp4)
    );

    // Reference model: counts enabled cycles since Start and derives Count/Done/Expired
    // arithmetically from the elapsed-cycle total. Index 0 is PRESCALE 1, index 1 is 4.
    longint       ecyc    [2] = '{0, 0};
    logic [W-1:0] m_count [2] = '{0, 0};
    logic [W-1:0] m_lim   [2] = '{0, 0};
    logic         m_mode  [2] = '{0, 0};
    logic         m_run   [2] = '{0, 0};
    logic         m_done  [2] = '{0, 0};
    logic         m_exp   [2] = '{0, 0};

    function automatic longint pre(input int k);
        return (k == 0) ? 64'd1 : 64'd4;
    endfunction

    function automatic longint period(input int k);
        return pre(k) * (longint'(m_lim[k]) + 64'd1);
    endfunction

    always @(posedge Clock) begin
        for (int k = 0; k < 2; k++) begin
            if (!Reset) begin
                ecyc[k] <= 0; m_count[k] <= '0; m_lim[k] <= '0; m_mode[k] <= 1'b0;
                m_run[k] <= 1'b0; m_done[k] <= 1'b0; m_exp[k] <= 1'b0;
            end else if (Stop) begin
                m_run[k] <= 1'b0; m_exp[k] <= 1'b0; m_done[k] <= 1'b0;
            end else if (Start) begin
                ecyc[k] <= 0; m_count[k] <= '0; m_lim[k] <= Limit; m_mode[k] <= Mode;
                m_run[k] <= 1'b1; m_exp[k] <= 1'b0; m_done[k] <= 1'b0;
            end else if (m_run[k] && Enable) begin
                ecyc[k] <= ecyc[k] + 1;
                if ((ecyc[k] + 1) % period(k) == 0) begin
                    m_done[k] <= 1'b1;
                    if (!m_mode[k]) begin
                        m_run[k] <= 1'b0; m_exp[k] <= 1'b1; m_count[k] <= m_lim[k];
                    end else begin
                        m_count[k] <= '0;
                    end
                end else begin
                    m_done[k]  <= 1'b0;
                    m_count[k] <= W'(((ecyc[k] + 1) / pre(k)) % (longint'(m_lim[k]) + 1));
                end
            end else begin
                m_done[k] <= 1'b0;
            end
        end
    end

    function automatic logic [27:0] mv();
        return {m_count[0], m_run[0], m_done[0], m_exp[0],
                m_count[1], m_run[1], m_done[1], m_exp[1]};
    endfunction

    wire [27:0] dv = {count1, run1, done1, exp1, count4, run4, done4, exp4};

    task automatic cyc();
        @(posedge Clock);
        @(negedge Clock);
    endtask

    task automatic pulse_start(input logic [W-1:0] lim, input logic md);
        Start = 1'b1; Limit = lim; Mode = md;
        cyc();
        Start = 1'b0;
    endtask

    task automatic test_reset();
        Reset = 1'b0; Start = 1'b1; Enable = 1'b1; Stop = 1'b0; Limit = 11'd5; Mode = 1'b1;
        repeat (3) cyc();
        tests++;
        if (dv !== 28'h0) begin fails++; $display("FAIL reset_outputs: got %h expected %h", dv, 28'h0); end
        tests++;
        if (dv !== mv()) begin fails++; $display("FAIL reset_model: got %h expected %h", dv, mv()); end
        Reset = 1'b1; Start = 1'b0;
        cyc();
    endtask

    task automatic test_oneshot();
        int nd = 0, dc = -1;
        Enable = 1'b1;
        pulse_start(11'd5, 1'b0);
        tests++;
        if ({count1, run1} !== {11'd0, 1'b1}) begin
            fails++; $display("FAIL oneshot_start: got %h/%b expected 0/1", count1, run1);
        end
        for (int i = 1; i <= 20; i++) begin
            cyc();
            tests++;
            if (dv !== mv()) begin fails++; $display("FAIL oneshot_model c%0d: got %h expected %h", i, dv, mv()); end
            if (done1) begin nd++; dc = i; end
        end
        tests++;
        if (nd !== 1 || dc !== 6) begin fails++; $display("FAIL oneshot_done: got n=%0d at %0d expected n=1 at 6", nd, dc); end
        tests++;
        if ({exp1, run1, count1} !== {1'b1, 1'b0, 11'd5}) begin
            fails++; $display("FAIL oneshot_hold: got exp=%b run=%b cnt=%0d expected 1 0 5", exp1, run1, count1);
        end
    endtask

    task automatic test_periodic();
        int times[$];
        int rb = 0;
        Enable = 1'b1;
        pulse_start(11'd2, 1'b1);
        for (int i = 1; i <= 40; i++) begin
            cyc();
            tests++;
            if (dv !== mv()) begin fails++; $display("FAIL periodic_model c%0d: got %h expected %h", i, dv, mv()); end
            tests++;
            if (count4 !== W'((i / 4) % 3)) begin
                fails++; $display("FAIL periodic_count c%0d: got %0d expected %0d", i, count4, (i / 4) % 3);
            end
            if (done4) times.push_back(i);
            if (!run4) rb++;
        end
        tests++;
        if (times.size() < 3) begin fails++; $display("FAIL periodic_pulses: got %0d expected >=3", times.size()); end
        for (int j = 0; j < times.size(); j++) begin
            tests++;
            if (times[j] !== 12 * (j + 1)) begin
                fails++; $display("FAIL periodic_spacing #%0d: got %0d expected %0d", j, times[j], 12 * (j + 1));
            end
        end
        tests++;
        if (rb !== 0) begin fails++; $display("FAIL periodic_running: got %0d low cycles expected 0", rb); end
    endtask

    task automatic test_pause();
        int dc = -1;
        Enable = 1'b1;
        pulse_start(11'd10, 1'b0);
        for (int i = 1; i <= 40; i++) begin
            if (i == 5) Enable = 1'b0;
            if (i == 12) Enable = 1'b1;
            cyc();
            tests++;
            if (dv !== mv()) begin fails++; $display("FAIL pause_model c%0d: got %h expected %h", i, dv, mv()); end
            if (done1 && dc < 0) dc = i;
        end
        tests++;
        if (dc !== 18) begin fails++; $display("FAIL pause_delay: got %0d expected 18", dc); end
        Enable = 1'b1;
    endtask

    task automatic test_stop();
        int nd = 0;
        bit hit = 0;
        Enable = 1'b1;
        pulse_start(11'd10, 1'b0);
        for (int i = 0; i < 20 && !hit; i++) begin
            if (count1 == 11'd4) hit = 1; else cyc();
        end
        tests++;
        if (!hit) begin fails++; $display("FAIL stop_wait: got timeout expected Count=4"); end
        Stop = 1'b1;
        cyc();
        Stop = 1'b0;
        tests++;
        if ({run1, exp1, done1, count1} !== {3'b000, 11'd4}) begin
            fails++; $display("FAIL stop_idle: got run=%b exp=%b done=%b cnt=%0d expected 0 0 0 4", run1, exp1, done1, count1);
        end
        for (int i = 1; i <= 30; i++) begin
            cyc();
            tests++;
            if (dv !== mv()) begin fails++; $display("FAIL stop_model c%0d: got %h expected %h", i, dv, mv()); end
            if (done1 || done4) nd++;
        end
        tests++;
        if (nd !== 0 || count1 !== 11'd4) begin fails++; $display("FAIL stop_nodone: got %0d pulses cnt=%0d expected 0 and 4", nd, count1); end
    endtask

    task automatic test_limit_zero();
        int d1 = -1, d4 = -1;
        Enable = 1'b1;
        pulse_start(11'd0, 1'b0);
        for (int i = 1; i <= 10; i++) begin
            cyc();
            tests++;
            if (dv !== mv()) begin fails++; $display("FAIL lim0_model c%0d: got %h expected %h", i, dv, mv()); end
            if (done1 && d1 < 0) d1 = i;
            if (done4 && d4 < 0) d4 = i;
        end
        tests++;
        if (d1 !== 1 || d4 !== 4) begin fails++; $display("FAIL lim0_done: got %0d/%0d expected 1/4", d1, d4); end
    endtask

    task automatic test_limit_max();
        int d1 = -1, d4 = -1;
        Enable = 1'b1;
        pulse_start(11'd2047, 1'b0);
        for (int i = 1; i <= 8200; i++) begin
            cyc();
            tests++;
            if (dv !== mv()) begin fails++; $display("FAIL limmax_model c%0d: got %h expected %h", i, dv, mv()); end
            if (done1 && d1 < 0) d1 = i;
            if (done4 && d4 < 0) d4 = i;
        end
        tests++;
        if (d1 !== 2048 || d4 !== 8192) begin fails++; $display("FAIL limmax_done: got %0d/%0d expected 2048/8192", d1, d4); end
        tests++;
        if ({exp1, count1} !== {1'b1, 11'd2047}) begin fails++; $display("FAIL limmax_hold: got exp=%b cnt=%0d expected 1 2047", exp1, count1); end
    endtask

    task automatic test_start_on_terminal();
        Enable = 1'b1;
        pulse_start(11'd3, 1'b1);
        repeat (3) cyc();
        tests++;
        if (count1 !== 11'd3) begin fails++; $display("FAIL term_pre: got %0d expected 3", count1); end
        pulse_start(11'd3, 1'b1);
        tests++;
        if ({count1, done1, run1} !== {11'd0, 1'b0, 1'b1}) begin
            fails++; $display("FAIL term_restart: got cnt=%0d done=%b run=%b expected 0 0 1", count1, done1, run1);
        end
        for (int i = 1; i <= 6; i++) begin
            cyc();
            tests++;
            if (dv !== mv()) begin fails++; $display("FAIL term_model c%0d: got %h expected %h", i, dv, mv()); end
        end
    endtask

    task automatic test_start_stop();
        Enable = 1'b1;
        pulse_start(11'd7, 1'b1);
        repeat (2) cyc();
        Start = 1'b1; Stop = 1'b1;
        cyc();
        Start = 1'b0; Stop = 1'b0;
        tests++;
        if ({run1, run4, done1, done4, exp1, exp4} !== 6'b0) begin
            fails++; $display("FAIL startstop_idle: got %b expected 000000", {run1, run4, done1, done4, exp1, exp4});
        end
        repeat (5) cyc();
        tests++;
        if (dv !== mv() || run1 !== 1'b0) begin fails++; $display("FAIL startstop_hold: got %h expected %h", dv, mv()); end
    endtask

    task automatic test_reset_mid();
        int dc = -1;
        bit hit = 0;
        Enable = 1'b1;
        pulse_start(11'd10, 1'b0);
        for (int i = 0; i < 20 && !hit; i++) begin
            if (count1 == 11'd3) hit = 1; else cyc();
        end
        tests++;
        if (!hit) begin fails++; $display("FAIL rstmid_wait: got timeout expected Count=3"); end
        Reset = 1'b0;
        cyc();
        Reset = 1'b1;
        tests++;
        if (dv !== 28'h0) begin fails++; $display("FAIL rstmid_outputs: got %h expected %h", dv, 28'h0); end
        pulse_start(11'd5, 1'b0);
        for (int i = 1; i <= 10; i++) begin
            cyc();
            if (done1 && dc < 0) dc = i;
        end
        tests++;
        if (dc !== 6) begin fails++; $display("FAIL rstmid_restart: got %0d expected 6", dc); end
    endtask

    task automatic test_random();
        int nf = 0;
        for (int i = 0; i < 3000; i++) begin
            Reset  = ($urandom_range(0, 299) != 0);
            Enable = ($urandom_range(0, 9) != 0);
            Start  = ($urandom_range(0, 39) == 0);
            Stop   = ($urandom_range(0, 79) == 0);
            Mode   = 1'($urandom);
            Limit  = W'($urandom_range(0, 15));
            cyc();
            tests++;
            if (dv !== mv()) begin
                fails++; nf++;
                if (nf <= 10) $display("FAIL random_model c%0d: got %h expected %h", i, dv, mv());
            end
        end
        Reset = 1'b1; Start = 1'b0; Stop = 1'b0; Enable = 1'b1;
    endtask

    initial begin
        @(negedge Clock);
        test_reset();
        test_oneshot();
        test_periodic();
        test_pause();
        test_stop();
        test_limit_zero();
        test_limit_max();
        test_start_on_terminal();
        test_start_stop();
        test_reset_mid();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
